hazard_unit_param: RTL

HAZARD_UNIT_PARAM -- requirements
Module: hazard_unit_param

---
 rtl/hazard_unit_param_if.sv | 40 ++++
 rtl/hazard_unit_param.sv | 132 +++++++++++++
 2 files changed

// File: rtl/hazard_unit_param_if.sv
// Pipeline hazard bus: stage register addresses and write-valids in,
// stall/flush/forward controls and the stall-cycle counter out.
interface hazard_unit_param_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] id_ex_rd;
    logic [REG_AW-1:0] ex_mem_rd;
    logic [REG_AW-1:0] mem_wb_rd;
    logic              id_ex_reg_write;
    logic              ex_mem_reg_write;
    logic              mem_wb_reg_write;
    logic              id_ex_mem_read;
    logic              branch_taken;
    logic              mdu_start;
    logic              mdu_done;
    logic              stall;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [31:0]       stall_cnt;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd,
               id_ex_reg_write, ex_mem_reg_write, mem_wb_reg_write,
               id_ex_mem_read, branch_taken, mdu_start, mdu_done,
        input  stall, flush_if_id, flush_id_ex, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd,
               id_ex_reg_write, ex_mem_reg_write, mem_wb_reg_write,
               id_ex_mem_read, branch_taken, mdu_start, mdu_done,
        output stall, flush_if_id, flush_id_ex, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_unit_param.sv
// Pipeline hazard unit: operand forwarding, load-use / RAW stalls,
// multicycle MDU stall and multi-cycle branch flush, plus a stall counter.
module hazard_unit_param #(
    parameter int REG_AW       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int FWD_EN       = 1
) (
    input logic               clk,
    input logic               rst,
    hazard_unit_param_if.slave hz
);
    typedef enum logic [1:0] {IDLE, LDSTALL, MDU, FLUSH} state_e;

    localparam logic [1:0] LD_RELOAD = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;
    localparam logic [1:0] FL_RELOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
    localparam state_e     BR_STATE  = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
    localparam state_e     LD_STATE  = (LOAD_LAT > 1) ? LDSTALL : IDLE;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_c, flush_if_id_c, flush_id_ex_c;
    logic [1:0]  fwd_a_c, fwd_b_c;
    logic        lu, raw;

    // Register x0 is hard-wired zero, so it never creates a dependency.
    function automatic logic hit(input logic [REG_AW-1:0] rd, input logic we,
                                 input logic [REG_AW-1:0] rs);
        return we && (rd == rs) && (rd != '0);
    endfunction

    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        if (FWD_EN != 0) begin
            if (hit(hz.ex_mem_rd, hz.ex_mem_reg_write, hz.ex_rs1))      fwd_a_c = 2'b10;
            else if (hit(hz.mem_wb_rd, hz.mem_wb_reg_write, hz.ex_rs1)) fwd_a_c = 2'b01;
            if (hit(hz.ex_mem_rd, hz.ex_mem_reg_write, hz.ex_rs2))      fwd_b_c = 2'b10;
            else if (hit(hz.mem_wb_rd, hz.mem_wb_reg_write, hz.ex_rs2)) fwd_b_c = 2'b01;
        end
    end

    always_comb begin
        lu  = hz.id_ex_mem_read &&
              (hit(hz.id_ex_rd, hz.id_ex_reg_write, hz.id_rs1) ||
               hit(hz.id_ex_rd, hz.id_ex_reg_write, hz.id_rs2));
        raw = (FWD_EN == 0) &&
              (hit(hz.id_ex_rd,  hz.id_ex_reg_write,  hz.id_rs1) ||
               hit(hz.id_ex_rd,  hz.id_ex_reg_write,  hz.id_rs2) ||
               hit(hz.ex_mem_rd, hz.ex_mem_reg_write, hz.id_rs1) ||
               hit(hz.ex_mem_rd, hz.ex_mem_reg_write, hz.id_rs2) ||
               hit(hz.mem_wb_rd, hz.mem_wb_reg_write, hz.id_rs1) ||
               hit(hz.mem_wb_rd, hz.mem_wb_reg_write, hz.id_rs2));
    end

    // Controls are Mealy: a taken branch or new hazard acts in the same cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_c       = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        unique case (state_q)
            IDLE, LDSTALL, FLUSH: begin
                if (hz.branch_taken) begin
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                    state_d       = BR_STATE;
                    cnt_d         = FL_RELOAD;
                end else if (state_q == FLUSH) begin
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 2'd1;
                end else if (state_q == LDSTALL) begin
                    stall_c       = 1'b1;
                    flush_id_ex_c = 1'b1;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 2'd1;
                end else if (hz.mdu_start) begin
                    if (!hz.mdu_done) begin
                        stall_c = 1'b1;
                        state_d = MDU;
                    end
                end else if (lu) begin
                    stall_c       = 1'b1;
                    flush_id_ex_c = 1'b1;
                    state_d       = LD_STATE;
                    cnt_d         = LD_RELOAD;
                end else if (raw) begin
                    stall_c       = 1'b1;
                    flush_id_ex_c = 1'b1;
                end
            end
            MDU: begin
                stall_c = !hz.mdu_done;
                if (hz.mdu_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            stall_c       = 1'b0;
            flush_if_id_c = 1'b0;
            flush_id_ex_c = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall       = stall_c;
    assign hz.flush_if_id = flush_if_id_c;
    assign hz.flush_id_ex = flush_id_ex_c;
    assign hz.fwd_a       = fwd_a_c;
    assign hz.fwd_b       = fwd_b_c;
    assign hz.stall_cnt   = stall_cnt_q;
endmodule
